// File: rtl/glyph_row_serializer.sv
// rtl/glyph_row_serializer.sv - glyph ROM fetch and row pixel serializer
//
// Takes one (character, row) request at a time, maps the character code to a
// glyph ROM index, reads one row from an external synchronous ROM and shifts
// it out one pixel per accepted beat, followed by GAP background pixels.
//
// Optional feature macro: GLYPH_INVERSE_EN (inverse-video attribute per char)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_char, req_row, req_inv character code, glyph row, inverse attribute
//   rom_addr, rom_data         glyph ROM index (registered) and ROM word
//   pixel_valid/pixel_ready    pixel stream handshake
//   pixel_out, pixel_last      pixel value and final-beat-of-character flag
module glyph_row_serializer #(
  parameter int GLYPH_W  = 5,
  parameter int GLYPH_H  = 7,
  parameter int GAP      = 1,
  parameter int CHAR_MIN = 32,
  parameter int CHAR_MAX = 127,
  parameter int ROW_W    = 3,
  parameter int ROM_AW   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [6:0]                 req_char,
  input  logic [ROW_W-1:0]           req_row,
  input  logic                       req_inv,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
  output logic                       pixel_valid,
  input  logic                       pixel_ready,
  output logic                       pixel_out,
  output logic                       pixel_last
);

  localparam int BEATS = GLYPH_W + GAP;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA, F_FULL} fstate_t;

  fstate_t            state, state_nxt;
  logic               ready_en;
  logic [ROW_W-1:0]   row_q;
  logic [ROM_AW-1:0]  mapped_addr;
  logic [GLYPH_W-1:0] row_bits;
  logic [GLYPH_W-1:0] buf_bits;
  logic [GLYPH_W-1:0] sh_bits;
  logic [CW-1:0]      sh_cnt;
  logic               sh_valid;
  logic               sh_inv;
  logic               accept;
  logic               sh_last;
  logic               finishing;
  logic               sh_free;
  logic               load_data;
  logic               load_buf;

`ifdef GLYPH_INVERSE_EN
  logic inv_q;
  logic buf_inv;
  logic sh_inv_q;
  assign sh_inv = sh_inv_q;
`else
  logic unused_inv;
  assign unused_inv = req_inv;
  assign sh_inv     = 1'b0;
`endif

  assign accept    = req_valid && req_ready;
  assign sh_last   = sh_valid && (sh_cnt == CW'(BEATS - 1));
  assign finishing = sh_last && pixel_ready;
  // Shifter can take a new row this edge if empty or its last beat leaves now.
  assign sh_free   = !sh_valid || finishing;
  assign load_data = (state == F_DATA) && sh_free;
  assign load_buf  = (state == F_FULL) && sh_free;

  // Out-of-range codes fall back to the last glyph in the ROM.
  always_comb begin
    mapped_addr = ROM_AW'(CHAR_MAX - CHAR_MIN);
    if (int'(req_char) >= CHAR_MIN && int'(req_char) <= CHAR_MAX)
      mapped_addr = ROM_AW'(int'(req_char) - CHAR_MIN);
  end

  // Row r occupies a GLYPH_W slice with column 0 in its MSB; rows past the
  // glyph height read as background.
  always_comb begin
    row_bits = '0;
    for (int r = 0; r < GLYPH_H; r++) begin
      if (int'(row_q) == r)
        row_bits = rom_data[(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W];
    end
  end

  // Fetch FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nxt;
  end

  // Fetch FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:  if (accept) state_nxt = F_ADDR;
      F_ADDR:  state_nxt = F_DATA;
      F_DATA:  state_nxt = load_data ? F_IDLE : F_FULL;
      F_FULL:  if (load_buf) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  // Fetch FSM / shifter outputs
  always_comb begin
    req_ready   = ready_en && (state == F_IDLE);
    pixel_valid = sh_valid;
    pixel_last  = sh_last;
    pixel_out   = sh_valid && (sh_bits[GLYPH_W-1] ^ sh_inv);
  end

  // Request capture, row buffer and shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      rom_addr <= '0;
      row_q    <= '0;
      buf_bits <= '0;
      sh_bits  <= '0;
      sh_cnt   <= '0;
      sh_valid <= 1'b0;
`ifdef GLYPH_INVERSE_EN
      inv_q    <= 1'b0;
      buf_inv  <= 1'b0;
      sh_inv_q <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        rom_addr <= mapped_addr;
        row_q    <= req_row;
`ifdef GLYPH_INVERSE_EN
        inv_q    <= req_inv;
`endif
      end

      if (state == F_DATA && !sh_free) begin
        buf_bits <= row_bits;
`ifdef GLYPH_INVERSE_EN
        buf_inv  <= inv_q;
`endif
      end

      if (load_data || load_buf) begin
        sh_bits  <= load_data ? row_bits : buf_bits;
        sh_cnt   <= '0;
        sh_valid <= 1'b1;
`ifdef GLYPH_INVERSE_EN
        sh_inv_q <= load_data ? inv_q : buf_inv;
`endif
      end else if (finishing) begin
        sh_valid <= 1'b0;
      end else if (sh_valid && pixel_ready) begin
        // Zero fill makes the gap beats background once the glyph is out.
        sh_bits <= {sh_bits[GLYPH_W-2:0], 1'b0};
        sh_cnt  <= sh_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glyph_row_serializer.sv
// tb/tb_glyph_row_serializer.sv - directed-vector bench for glyph_row_serializer
module tb_glyph_row_serializer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_char;
  logic [2:0]  req_row;
  logic        req_inv;
  logic [6:0]  rom_addr;
  logic [34:0] rom_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_out;
  logic        pixel_last;

  glyph_row_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_char    (req_char),
    .req_row     (req_row),
    .req_inv     (req_inv),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_out   (pixel_out),
    .pixel_last  (pixel_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [34:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int acc_cyc;

  bit pix_q[$];
  bit last_q[$];
  int cyc_q[$];

  always @(negedge clk) begin
    if (rst_n && pixel_valid && pixel_ready) begin
      pix_q.push_back(pixel_out);
      last_q.push_back(pixel_last);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q;
    pix_q.delete();
    last_q.delete();
    cyc_q.delete();
  endtask

  task automatic send_req(input logic [6:0] c, input logic [2:0] r, input logic inv);
    int k = 0;
    req_char  = c;
    req_row   = r;
    req_inv   = inv;
    req_valid = 1'b1;
    while (!req_ready && k < 100) begin
      tick();
      k++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    @(posedge clk);
    acc_cyc = cyc;
    #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_pix(input int n);
    int k = 0;
    while (pix_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    if (pix_q.size() < n) check("pixel_timeout", pix_q.size(), n);
  endtask

  function automatic logic [31:0] pix_vec(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], pix_q[i]};
    return v;
  endfunction

  function automatic logic [31:0] last_vec(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], last_q[i]};
    return v;
  endfunction

  // Request one row, check ROM index and the six pixels with pixel_last.
  task automatic one_row(input string tag, input logic [6:0] c, input logic [2:0] r,
                         input logic [6:0] exp_addr, input logic [5:0] exp_pix);
    clear_q();
    send_req(c, r, 1'b0);
    check({tag, "_addr"}, rom_addr, exp_addr);
    wait_pix(6);
    check({tag, "_pix"}, pix_vec(6), exp_pix);
    check({tag, "_last"}, last_vec(6), 6'b000001);
    tick();
    tick();
    check({tag, "_idle"}, pixel_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    // 'A': 01110 10001 10001 11111 10001 10001 10001
    rom[33] = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
    // fallback glyph: 10101 on every row
    rom[95] = {7{5'b10101}};
    rom_data    = '0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_char    = '0;
    req_row     = '0;
    req_inv     = 1'b0;
    pixel_ready = 1'b1;

    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_pixel_last", pixel_last, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", req_ready, 0);
    tick();
    check("rel_req_ready_high", req_ready, 1);

    // Basic fetch with latency and consecutive beats
    clear_q();
    send_req(7'd65, 3'd0, 1'b0);
    check("basic_addr", rom_addr, 33);
    wait_pix(6);
    check("basic_pix", pix_vec(6), 6'b011100);
    check("basic_last", last_vec(6), 6'b000001);
    check("basic_latency", cyc_q[0] - acc_cyc, 3);
    check("basic_contig", cyc_q[5] - cyc_q[0], 5);
    tick();
    tick();
    check("basic_idle", pixel_valid, 0);

    // Code remap boundaries and row beyond the glyph
    one_row("char8",   7'd8,   3'd0, 7'd95, 6'b101010);
    one_row("char127", 7'd127, 3'd0, 7'd95, 6'b101010);
    one_row("char31",  7'd31,  3'd2, 7'd95, 6'b101010);
    one_row("char32",  7'd32,  3'd0, 7'd0,  6'b000000);
    one_row("row7",    7'd65,  3'd7, 7'd33, 6'b000000);
    one_row("row6",    7'd65,  3'd6, 7'd33, 6'b100010);

    // Back-to-back: three characters, gapless
    clear_q();
    send_req(7'd65, 3'd3, 1'b0);
    send_req(7'd8,  3'd0, 1'b0);
    send_req(7'd65, 3'd1, 1'b0);
    wait_pix(18);
    check("b2b_pix", pix_vec(18), 18'b111110_101010_100010);
    check("b2b_last", last_vec(18), 18'b000001_000001_000001);
    check("b2b_gapless", cyc_q[17] - cyc_q[0], 17);
    tick();
    tick();
    check("b2b_idle", pixel_valid, 0);

    // Stall three cycles on the third pixel (value 1)
    clear_q();
    send_req(7'd65, 3'd0, 1'b0);
    wait_pix(2);
    pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", pixel_valid, 1);
      check("stall_out", pixel_out, 1);
      check("stall_last", pixel_last, 0);
    end
    check("stall_count", pix_q.size(), 2);
    pixel_ready = 1'b1;
    wait_pix(6);
    tick();
    tick();
    check("stall_total", pix_q.size(), 6);
    check("stall_pix", pix_vec(6), 6'b011100);
    check("stall_last_vec", last_vec(6), 6'b000001);

`ifdef GLYPH_INVERSE_EN
    clear_q();
    send_req(7'd65, 3'd0, 1'b1);
    wait_pix(6);
    check("inv_pix", pix_vec(6), 6'b100011);
    check("inv_last", last_vec(6), 6'b000001);
    one_row("inv_after", 7'd65, 3'd0, 7'd33, 6'b011100);
`endif

    // Reset mid-character
    clear_q();
    send_req(7'd65, 3'd3, 1'b0);
    wait_pix(2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", pixel_valid, 0);
    check("midrst_out", pixel_out, 0);
    check("midrst_last", pixel_last, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_addr", rom_addr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_residue", pix_q.size(), 0);
    check("midrst_ready_back", req_ready, 1);
    one_row("post_rst", 7'd65, 3'd3, 7'd33, 6'b111110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
